// File: rtl/operand_b_select_pipe.sv
// ALU source-B selector with immediate formatting, a valid/ready output stage backed by a
// 2-entry skid buffer, and a sticky flag for illegal selector codes.
module operand_b_select_pipe #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned IMM_W     = 16,
    parameter int unsigned CONST_VAL = 4,
    parameter int unsigned SHIFT_AMT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        selector,
    input  logic [DATA_W-1:0] data_0,
    input  logic [IMM_W-1:0]  imm_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_sel,
    input  logic              err_clear
);

    function automatic logic [DATA_W-1:0] f_select_operand(
        input logic [2:0]        sel,
        input logic [DATA_W-1:0] d0,
        input logic [IMM_W-1:0]  imm
    );
        logic [DATA_W-1:0] sext;
        logic [DATA_W-1:0] zext;
        logic [DATA_W-1:0] result;
        sext = DATA_W'($signed(imm));
        zext = DATA_W'(imm);
        case (sel)
            3'd0:    result = d0;
            3'd1:    result = DATA_W'(CONST_VAL);
            3'd2:    result = sext;
            3'd3:    result = sext << SHIFT_AMT;
            3'd4:    result = zext;
            3'd5:    result = zext << (DATA_W - IMM_W);
            default: result = '0;
        endcase
        return result;
    endfunction

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_in_ready;
    logic              r_err_sel;

    logic              w_accept;
    logic              w_drain;
    logic              w_illegal;
    logic [DATA_W-1:0] w_operand;

    logic              w_main_valid_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic              w_err_nxt;

    assign w_accept  = in_valid && r_in_ready;
    assign w_drain   = r_main_valid && out_ready;
    assign w_illegal = (selector == 3'd6) || (selector == 3'd7);
    assign w_operand = f_select_operand(selector, data_0, imm_in);

    // Next-state of the main/skid pair; skid only fills while main is stalled.
    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        if (!r_main_valid || w_drain) begin
            if (r_skid_valid) begin
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = r_skid_data;
                w_skid_valid_nxt = 1'b0;
            end else if (w_accept) begin
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = w_operand;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_data_nxt  = w_operand;
        end else begin
            w_skid_valid_nxt = r_skid_valid;
        end
    end

    // Sticky error: a set on the same edge as a clear takes priority.
    always_comb begin
        w_err_nxt = r_err_sel;
        if (w_accept && w_illegal) begin
            w_err_nxt = 1'b1;
        end else if (err_clear) begin
            w_err_nxt = 1'b0;
        end else begin
            w_err_nxt = r_err_sel;
        end
    end

    // State registers with synchronous reset discarding any buffered operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_in_ready   <= 1'b1;
            r_err_sel    <= 1'b0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_data  <= w_main_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
            r_err_sel    <= w_err_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign data_out  = r_main_data;
    assign out_valid = r_main_valid;
    assign err_sel   = r_err_sel;

endmodule

// File: tb/tb_operand_b_select_pipe.sv
// Self-checking bench for operand_b_select_pipe: directed scenarios plus a randomized
// valid/ready run against a queue-based reference model.
module tb_operand_b_select_pipe;

    logic        clk;
    logic        reset;
    logic [2:0]  selector;
    logic [31:0] data_0;
    logic [15:0] imm_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_out;
    logic        out_valid;
    logic        out_ready;
    logic        err_sel;
    logic        err_clear;

    int tests_run;
    int tests_failed;

    operand_b_select_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .selector  (selector),
        .data_0    (data_0),
        .imm_in    (imm_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_sel   (err_sel),
        .err_clear (err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference operand computed with plain integer arithmetic (default parameters).
    function automatic logic [31:0] ref_op(input logic [2:0] sel, input logic [31:0] d0,
                                           input logic [15:0] imm);
        longint s;
        logic [31:0] r;
        s = (imm >= 16'h8000) ? (longint'(imm) - 65536) : longint'(imm);
        case (sel)
            3'd0:    r = d0;
            3'd1:    r = 32'd4;
            3'd2:    r = 32'(s);
            3'd3:    r = 32'(s * 4);
            3'd4:    r = 32'(longint'(imm));
            3'd5:    r = 32'(longint'(imm) * 65536);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        selector  = 3'd0;
        data_0    = 32'd0;
        imm_in    = 16'd0;
        err_clear = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 1'b1;
        do_reset();
        tests_run++;
        if ({out_valid, in_ready, err_sel, data_out} !== {1'b0, 1'b1, 1'b0, 32'd0}) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%b rdy=%b err=%b d=%h, want v=0 rdy=1 err=0 d=0",
                     out_valid, in_ready, err_sel, data_out);
        end
    endtask

    task automatic test_sources();
        logic [2:0]  sels [6];
        logic [15:0] imms [6];
        logic [31:0] exps [6];
        sels = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        imms = '{16'h0000, 16'h0000, 16'h8000, 16'hFFFF, 16'h8000, 16'h1234};
        exps = '{32'hDEADBEEF, 32'h00000004, 32'hFFFF8000, 32'hFFFFFFFC, 32'h00008000, 32'h12340000};
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            selector = sels[k];
            data_0   = 32'hDEADBEEF;
            imm_in   = imms[k];
            step();
            tests_run++;
            if (out_valid !== 1'b1 || data_out !== exps[k] || err_sel !== 1'b0) begin
                tests_failed++;
                $display("FAIL source_sel%0d: got v=%b d=%h err=%b, want v=1 d=%h err=0",
                         k, out_valid, data_out, err_sel, exps[k]);
            end
        end
        idle_inputs();
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL source_drain: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        selector  = 3'd0;
        data_0    = 32'h11;
        step();
        data_0 = 32'h22;
        step();
        tests_run++;
        if (in_ready !== 1'b0 || data_out !== 32'h11 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_full: got rdy=%b d=%h v=%b, want rdy=0 d=11 v=1", in_ready, data_out, out_valid);
        end
        data_0 = 32'h33;
        step();
        tests_run++;
        if (in_ready !== 1'b0 || data_out !== 32'h11) begin
            tests_failed++;
            $display("FAIL bp_hold: got rdy=%b d=%h, want rdy=0 d=11", in_ready, data_out);
        end
        out_ready = 1'b1;
        step();
        tests_run++;
        if (in_ready !== 1'b1 || data_out !== 32'h22 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_second: got rdy=%b d=%h v=%b, want rdy=1 d=22 v=1", in_ready, data_out, out_valid);
        end
        step();
        tests_run++;
        if (data_out !== 32'h33 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_third: got d=%h v=%b, want d=33 v=1", data_out, out_valid);
        end
        idle_inputs();
        step();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_empty: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        selector  = 3'd6;
        data_0    = 32'hCAFEF00D;
        imm_in    = 16'h7777;
        step();
        tests_run++;
        if (data_out !== 32'd0 || err_sel !== 1'b1 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_set: got d=%h err=%b v=%b, want d=0 err=1 v=1", data_out, err_sel, out_valid);
        end
        idle_inputs();
        step();
        step();
        tests_run++;
        if (err_sel !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_sticky: got err=%b, want 1", err_sel);
        end
        in_valid  = 1'b1;
        selector  = 3'd1;
        err_clear = 1'b1;
        step();
        tests_run++;
        if (err_sel !== 1'b0 || data_out !== 32'd4) begin
            tests_failed++;
            $display("FAIL illegal_clear: got err=%b d=%h, want err=0 d=4", err_sel, data_out);
        end
        selector = 3'd7;
        step();
        tests_run++;
        if (err_sel !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_set_wins: got err=%b, want 1", err_sel);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_invalid_ignored();
        do_reset();
        in_valid = 1'b0;
        selector = 3'd6;
        step();
        step();
        tests_run++;
        if (err_sel !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL invalid_ignored: got err=%b v=%b, want err=0 v=0", err_sel, out_valid);
        end
        idle_inputs();
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        selector  = 3'd0;
        data_0    = 32'hAAAA0001;
        step();
        data_0 = 32'hAAAA0002;
        step();
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstfull_pre: got rdy=%b v=%b, want rdy=0 v=1", in_ready, out_valid);
        end
        reset    = 1'b1;
        selector = 3'd1;
        step();
        reset = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== 32'd0) begin
            tests_failed++;
            $display("FAIL rstfull_post: got v=%b rdy=%b d=%h, want v=0 rdy=1 d=0", out_valid, in_ready, data_out);
        end
        out_ready = 1'b1;
        step();
        tests_run++;
        if (out_valid !== 1'b1 || data_out !== 32'd4) begin
            tests_failed++;
            $display("FAIL rstfull_after: got v=%b d=%h, want v=1 d=4", out_valid, data_out);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic        exp_err;
        logic        acc;
        logic        drn;
        logic        stall;
        logic [31:0] held;
        logic [31:0] want;
        int          errs;
        errs = 0;
        idle_inputs();
        do_reset();
        exp_err = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            selector  = ($urandom_range(0, 99) < 8) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            data_0    = $urandom;
            imm_in    = 16'($urandom);
            out_ready = ($urandom_range(0, 99) < 55);
            err_clear = ($urandom_range(0, 99) < 5);
            acc   = in_valid && in_ready;
            drn   = out_valid && out_ready;
            stall = out_valid && !out_ready;
            held  = data_out;
            if (drn) begin
                want = (q.size() > 0) ? q.pop_front() : 32'hBAD0BAD0;
                tests_run++;
                if (data_out !== want) begin
                    tests_failed++;
                    if (errs++ < 10)
                        $display("FAIL rand_data cyc%0d: got %h, want %h", i, data_out, want);
                end
            end
            if (acc) q.push_back(ref_op(selector, data_0, imm_in));
            if (acc && selector >= 3'd6) exp_err = 1'b1;
            else if (err_clear) exp_err = 1'b0;
            step();
            tests_run++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) || err_sel !== exp_err
                || (stall && data_out !== held)) begin
                tests_failed++;
                if (errs++ < 10)
                    $display("FAIL rand_state cyc%0d: got v=%b rdy=%b err=%b d=%h, want v=%b rdy=%b err=%b held=%h stall=%b",
                             i, out_valid, in_ready, err_sel, data_out, q.size() > 0, q.size() < 2,
                             exp_err, held, stall);
            end
        end
        idle_inputs();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        out_ready    = 1'b0;
        idle_inputs();
        test_reset();
        test_sources();
        test_backpressure();
        test_illegal();
        test_invalid_ignored();
        test_reset_full();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/operand_b_select_pipe.md
Name: operand_b_select_pipe

Overview:
- Parametrised, pipelined successor to the ALU source-B selector of the multicycle datapath.
- Selects the ALU B operand from one of six sources. It builds the immediate variants internally from a raw immediate.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so the control unit can stall the ALU without losing an operand.
- Flags illegal selector codes with a sticky error.

Parameters:
- DATA_W, 32, operand and output width (at least IMM_W+SHIFT_AMT).
- IMM_W, 16, raw immediate width (at most DATA_W).
- CONST_VAL, 4, value of the constant source (PC increment), truncated to DATA_W.
- SHIFT_AMT, 2, left shift applied to the branch-offset source.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- selector  input  3  source select, sampled with in_valid.
- data_0  input  DATA_W  B register value.
- imm_in  input  IMM_W  raw instruction immediate.
- in_valid  input  1  selector/data_0/imm_in are valid this cycle.
- in_ready  output  1  block can accept an input this cycle.
- data_out  output  DATA_W  selected operand.
- out_valid  output  1  data_out is valid.
- out_ready  input  1  consumer accepts data_out this cycle.
- err_sel  output  1  sticky: an illegal selector was accepted.
- err_clear  input  1  clears err_sel.

Behaviour:
- Source map (evaluated at acceptance):
  - 0: data_0.
  - 1: CONST_VAL.
  - 2: sign-extend imm_in to DATA_W.
  - 3: sign-extend imm_in, then shift left by SHIFT_AMT. Upper bits shifted out are discarded; zeros fill the bottom.
  - 4: zero-extend imm_in.
  - 5: imm_in placed in bits [DATA_W-1 : DATA_W-IMM_W], zeros below (LUI form).
  - 6, 7: illegal; the operand is 0 and err_sel is set.
- Acceptance: the input is accepted when in_valid && in_ready at a rising edge.
- Output drain: the output is consumed when out_valid && out_ready at a rising edge.
- Storage: a main register (drives data_out/out_valid) and a skid register (skid_valid).
- in_ready is registered and equals !skid_valid. It never depends combinationally on out_ready.
- Latency: an accepted operand appears on data_out with out_valid=1 the next cycle if the main register is empty or being drained that cycle.
- Per-edge update rules:
  - Main empty or drained, skid empty: an accepted operand loads main. With no acceptance, out_valid drops to 0.
  - Main full and not drained, input accepted: the operand loads skid, skid_valid=1, and in_ready falls the next cycle.
  - Main drained, skid full: skid moves to main, skid_valid=0, and in_ready rises the next cycle. No acceptance is possible that edge because in_ready=0.
- Ordering: operands leave strictly in acceptance order. No operand is dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, data_out holds stable.
- err_sel:
  - Set on the edge an illegal selector is accepted.
  - Cleared by err_clear.
  - If set and clear occur on the same edge, set wins.
  - Not affected by out_ready.
- Inputs are ignored when in_valid=0 or in_ready=0. A non-accepted illegal selector does not set err_sel.
- Reset (synchronous, can occur mid-transfer):
  - Next cycle: out_valid=0, data_out=0, skid_valid=0, in_ready=1, err_sel=0.
  - Any buffered operands are discarded.
  - Inputs presented in the reset cycle are not accepted.
- Throughput: 1 operand per cycle when out_ready is held at 1.

Test Plan:
- Reset, then out_ready=1. Back-to-back sel=0 data_0=0xDEADBEEF; sel=1; sel=2 imm=0x8000; sel=3 imm=0xFFFF; sel=4 imm=0x8000; sel=5 imm=0x1234. Required: outputs 0xDEADBEEF, 0x00000004, 0xFFFF8000, 0xFFFFFFFC, 0x00008000, 0x12340000 on consecutive cycles starting 1 cycle after the first accept; err_sel=0.
- Backpressure: out_ready=0 and accept A=0x11 then B=0x22. Required: in_ready=0 from the cycle after B; data_out holds 0x11. Then raise out_ready. Required: 0x11 then 0x22 delivered, in_ready returns to 1, no third operand lost.
- Illegal select: accept sel=6. Required: data_out=0, err_sel=1 next cycle and stays 1. Then err_clear=1 with a legal input. Required: err_sel=0. Also apply err_clear with simultaneous sel=7 accepted. Required: err_sel stays 1.
- sel=6 with in_valid=0 -> err_sel stays 0, out_valid stays 0.
- Reset with both main and skid full -> next cycle out_valid=0, in_ready=1, data_out=0; subsequent sel=1 accept -> 0x00000004 after 1 cycle.
- Random valid/ready toggling for 10k cycles against a FIFO scoreboard -> every accepted operand is delivered once, in order, with the correct value; data_out is stable while stalled.
